// File: rtl/alu_logic_arbiter.sv
// Two-requester bitwise-logic ALU with a round-robin arbiter.
// One operation is in flight at a time: IDLE accepts a request, EXEC
// computes from the captured operands, RESP holds the result until the
// consumer takes it.
module alu_logic_arbiter #(
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_op,
    input  logic [K-1:0] req0_a,
    input  logic [K-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_op,
    input  logic [K-1:0] req1_a,
    input  logic [K-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [K-1:0] rsp_data,
    output logic         rsp_err
);

    localparam logic [2:0] OP_NAND = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state_reg;
    logic         last_reg;      // requester granted most recently
    logic [2:0]   op_reg;
    logic [K-1:0] a_reg;
    logic [K-1:0] b_reg;
    logic         id_reg;
    logic         rsp_valid_reg;
    logic         rsp_id_reg;
    logic [K-1:0] rsp_data_reg;
    logic         rsp_err_reg;

    logic         grant0;
    logic         grant1;
    logic [K-1:0] result_next;
    logic         err_next;

    // Round-robin grant, only meaningful while IDLE; a tie goes to the
    // requester that was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_reg;
                grant1 = ~last_reg;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Readies are gated by rst_n so they drop the instant reset asserts.
    assign req0_ready = grant0 & rst_n;
    assign req1_ready = grant1 & rst_n;

    // Bitwise operation on the captured operands; unused opcodes flag an error.
    always_comb begin
        result_next = '0;
        err_next    = 1'b0;
        case (op_reg)
            OP_NAND: result_next = ~(a_reg & b_reg);
            OP_AND:  result_next = a_reg & b_reg;
            OP_OR:   result_next = a_reg | b_reg;
            OP_XOR:  result_next = a_reg ^ b_reg;
            OP_NOR:  result_next = ~(a_reg | b_reg);
            OP_NOT:  result_next = ~a_reg;
            default: err_next    = 1'b1;
        endcase
    end

    // Control FSM: capture on handshake, compute in EXEC, hold result in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            op_reg        <= '0;
            a_reg         <= '0;
            b_reg         <= '0;
            id_reg        <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0) begin
                        op_reg    <= req0_op;
                        a_reg     <= req0_a;
                        b_reg     <= req0_b;
                        id_reg    <= 1'b0;
                        last_reg  <= 1'b0;
                        state_reg <= EXEC;
                    end else if (grant1) begin
                        op_reg    <= req1_op;
                        a_reg     <= req1_a;
                        b_reg     <= req1_b;
                        id_reg    <= 1'b1;
                        last_reg  <= 1'b1;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_reg  <= result_next;
                    rsp_err_reg   <= err_next;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed bench for alu_logic_arbiter: linear steps, hand-computed results.
module tb_alu_logic_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [2:0]  req0_op = 3'b000;
    logic [15:0] req0_a = 16'h0000;
    logic [15:0] req0_b = 16'h0000;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [2:0]  req1_op = 3'b000;
    logic [15:0] req1_a = 16'h0000;
    logic [15:0] req1_b = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    alu_logic_arbiter #(.K(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-24s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset behaviour: outputs cleared, readies low even with a valid request.
        req0_valid = 1'b1;
        #2;
        check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // NAND FFFF/000A from requester 0: ready at T, response at T+2.
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 16'hFFFF; req0_b = 16'h000A;
        #1;
        check("nand_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("nand_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0;
        req0_a = 16'h0000;  // must not disturb captured operand
        check("nand_exec_ready", {31'd0, req0_ready}, 32'd0);
        check("nand_exec_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        check("nand_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("nand_rsp_data", {16'd0, rsp_data}, 32'h0000FFF5);
        check("nand_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("nand_rsp_err", {31'd0, rsp_err}, 32'd0);
        tick();
        check("nand_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("nand_data_held", {16'd0, rsp_data}, 32'h0000FFF5);

        // Round robin after a fresh reset: req0 first, then req1, then req0.
        do_reset();
        req0_valid = 1'b1; req0_op = 3'b001; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_valid = 1'b1; req1_op = 3'b011; req1_a = 16'hAAAA; req1_b = 16'hFFFF;
        #1;
        check("rr1_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("rr1_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        tick();
        check("rr1_rsp_data", {16'd0, rsp_data}, 32'h0000000F);
        check("rr1_rsp_id", {31'd0, rsp_id}, 32'd0);
        tick();
        check("rr2_req1_ready", {31'd0, req1_ready}, 32'd1);
        check("rr2_req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        tick();
        check("rr2_rsp_data", {16'd0, rsp_data}, 32'h00005555);
        check("rr2_rsp_id", {31'd0, rsp_id}, 32'd1);
        tick();
        check("rr3_req0_ready", {31'd0, req0_ready}, 32'd1);
        check("rr3_req1_ready", {31'd0, req1_ready}, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        check("rr_withdraw_valid", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: OR 1200/0034 held for five stalled cycles.
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op = 3'b010; req1_a = 16'h1200; req1_b = 16'h0034;
        #1;
        check("bp_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req0_op = 3'b011; req0_a = 16'h5A5A;
        req1_valid = 1'b1; req1_b = 16'hFFFF;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_rsp_data", {16'd0, rsp_data}, 32'h00001234);
            check("bp_rsp_id", {31'd0, rsp_id}, 32'd1);
            check("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("bp_complete_valid", {31'd0, rsp_valid}, 32'd1);
        tick();
        check("bp_after_valid", {31'd0, rsp_valid}, 32'd0);

        // Illegal opcode then NOT a.
        req0_valid = 1'b1; req0_op = 3'b111; req0_a = 16'h1234; req0_b = 16'h5678;
        #1;
        check("ill_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("ill_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("ill_rsp_data", {16'd0, rsp_data}, 32'd0);
        tick();
        req0_valid = 1'b1; req0_op = 3'b101; req0_a = 16'h0F0F; req0_b = 16'h1111;
        #1;
        check("not_req0_ready", {31'd0, req0_ready}, 32'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("not_rsp_data", {16'd0, rsp_data}, 32'h0000F0F0);
        check("not_rsp_err", {31'd0, rsp_err}, 32'd0);
        tick();

        // Reset during EXEC discards the NOR; re-issue yields FFFF from req1.
        req1_valid = 1'b1; req1_op = 3'b100; req1_a = 16'h0000; req1_b = 16'h0000;
        #1;
        check("nor_req1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("nor_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("nor_rst_data", {16'd0, rsp_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("nor_post_valid", {31'd0, rsp_valid}, 32'd0);
        req1_valid = 1'b1;
        #1;
        check("nor_reissue_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("nor_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("nor_rsp_data", {16'd0, rsp_data}, 32'h0000FFFF);
        check("nor_rsp_id", {31'd0, rsp_id}, 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
ALU_LOGIC_ARBITER -- requirements
Module: alu_logic_arbiter

Interface
REQ-001 Parameter K, default 16, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 req0_valid  input  1  SHALL indicate requester 0 presents an operation.
REQ-005 req0_ready  output  1  SHALL indicate requester 0's operation is accepted this cycle.
REQ-006 req0_op  input  3  SHALL be requester 0's opcode.
REQ-007 req0_a, req0_b  input  K each  SHALL be requester 0's operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b SHALL mirror REQ-004..007 for requester 1.
REQ-009 rsp_valid  output  1  SHALL indicate a result is presented.
REQ-010 rsp_ready  input  1  SHALL indicate the consumer accepts the result.
REQ-011 rsp_id  output  1  SHALL identify the requester that owns the result (0 or 1).
REQ-012 rsp_data  output  K  SHALL carry the result.
REQ-013 rsp_err  output  1  SHALL flag an illegal opcode.

Function
REQ-014 Opcodes SHALL be: 000 NAND ~(a&b), 001 AND, 010 OR, 011 XOR, 100 NOR, 101 NOT a; all operations bitwise over K bits.
REQ-015 Opcodes 110 and 111 SHALL produce rsp_data = 0 and rsp_err = 1; legal opcodes SHALL produce rsp_err = 0.
REQ-016 FSM SHALL have states IDLE, EXEC, RESP; transitions: IDLE->EXEC on a handshake, EXEC->RESP unconditionally, RESP->IDLE when rsp_ready = 1, RESP holds otherwise.
REQ-017 In IDLE, arbitration SHALL be combinational: only one valid -> that requester is granted; both valid -> the requester not granted last is granted (round-robin).
REQ-018 reqN_ready SHALL be 1 only in IDLE and only for the granted requester; at most one ready is high per cycle; both ready = 0 in EXEC and RESP.
REQ-019 On a handshake (reqN_valid & reqN_ready) the block SHALL register op, a, b and requester id, and update the last-granted pointer to N.
REQ-020 In EXEC the block SHALL compute the result from the registered operands and register rsp_data, rsp_err, rsp_id.
REQ-021 Latency: handshake in cycle T SHALL give rsp_valid = 1 in cycle T+2; minimum issue interval is 3 cycles.
REQ-022 rsp_valid SHALL be 1 exactly in RESP; the response completes on the cycle rsp_valid & rsp_ready.
REQ-023 While rsp_valid = 1 and rsp_ready = 0, rsp_data, rsp_err and rsp_id SHALL be held stable.
REQ-024 Input changes on a non-granted requester, or on any requester outside IDLE, SHALL not affect the in-flight operation.
REQ-025 A requester deasserting valid before being granted SHALL lose nothing; no operation is recorded for it.
REQ-026 rsp_data, rsp_err, rsp_id SHALL hold their last values after the response completes until the next EXEC.

Reset
REQ-027 rst_n = 0 SHALL immediately force: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, rsp_id 0, last-granted pointer = 1 (requester 0 wins the first tie).
REQ-028 Reset asserted in EXEC or RESP SHALL discard the in-flight operation without producing a response; the requester must re-issue.
REQ-029 While rst_n = 0, req0_ready and req1_ready SHALL be 0.

Verification
REQ-030 After reset, req0 NAND a=FFFF b=000A -> req0_ready=1 at T, rsp_valid=1 at T+2, rsp_data=FFF5, rsp_id=0, rsp_err=0.
REQ-031 After reset, req0 AND 00FF/0F0F and req1 XOR AAAA/FFFF held valid together, rsp_ready=1 -> req0 granted first (rsp 000F, id 0), then req1 (rsp 5555, id 1), then req0 again if still valid.
REQ-032 req1 OR 1200/0034, rsp_ready=0 for 5 cycles -> rsp_valid=1 with rsp_data=1234 stable throughout, both ready=0, completes on the cycle rsp_ready rises.
REQ-033 req0 op=111 a=1234 b=5678 -> rsp_err=1, rsp_data=0000; next legal op NOT a=0F0F -> rsp_data=F0F0, rsp_err=0.
REQ-034 req1 NOR 0000/0000 accepted, rst_n=0 during EXEC -> rsp_valid=0 immediately and remains 0 after release; re-issued request yields rsp_data=FFFF, id 1.
